// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status strobes out.
interface uart_rx_if;
  logic       uart_rx_i;
  logic [7:0] data_byte_out;
  logic       byte_valid;
  logic       frame_error;
  logic       rx_busy;

  // Receiver: listens to the line, drives byte and status
  modport master (
    input  uart_rx_i,
    output data_byte_out,
    output byte_valid,
    output frame_error,
    output rx_busy
  );

  // Consumer / line driver side
  modport slave (
    output uart_rx_i,
    input  data_byte_out,
    input  byte_valid,
    input  frame_error,
    input  rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling from a tick counter,
// one-cycle strobes for a good byte or a bad stop bit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for a low level on the synchronised line
// START   | start bit seen, re-check it at mid-bit to reject glitches
// DATA    | sampling 8 data bits, one per bit period, LSB first
// STOP    | sampling stop bit; high -> publish byte, low -> frame error
// RECOVER | after a bad stop bit, wait for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master rx_if
);

  localparam int          HALF_BIT  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [13:0] HALF_TICK = 14'(HALF_BIT);
  localparam logic [13:0] LAST_TICK = 14'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic [13:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
  logic        rx_s;

  assign rx_s = sync2_q;

  // Next-state, counters and strobes; every state entry clears baud_cnt
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 14'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          baud_cnt_d = '0;
        end
      end
      START: begin
        if (baud_cnt_q == HALF_TICK) begin
          baud_cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_cnt_q == LAST_TICK) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_cnt_q == LAST_TICK) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RECOVER;
          end
        end
      end
      RECOVER: begin
        if (rx_s) begin
          state_d    = IDLE;
          baud_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state, synchroniser and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_if.uart_rx_i;
      sync2_q    <= sync1_q;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_if.data_byte_out = data_q;
  assign rx_if.byte_valid    = valid_q;
  assign rx_if.frame_error   = ferr_q;
  assign rx_if.rx_busy       = busy_q;

endmodule
